data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 16384, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter: IO_BASE, 32'h1100_0000, lowest address routed to the IO bus.
REQ-003 SHALL have port: MEM_CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: MEM_RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: MEM_ADDR2  input  32  byte address of data access.
REQ-006 SHALL have port: MEM_DIN2  input  32  store data, right-justified.
REQ-007 SHALL have port: MEM_WE2  input  1  store request this cycle.
REQ-008 SHALL have port: MEM_RDEN2  input  1  load request this cycle.
REQ-009 SHALL have port: MEM_SIZE  input  3  funct3; [1:0] 00 byte, 01 half, 10 word; [2] 1 = zero-extend.
REQ-010 SHALL have port: IOBUS_IN  input  32  read data from IO devices.
REQ-011 SHALL have port: MEM_DOUT2  output  32  load result, extended to 32 bits.
REQ-012 SHALL have port: IO_WR  output  1  IO store strobe.
REQ-013 SHALL have port: MEM_ERR  output  1  sticky misaligned/illegal-size flag.

Function
REQ-014 Region decode SHALL be: MEM_ADDR2 >= IO_BASE -> IO, else RAM.
REQ-015 RAM word index SHALL be MEM_ADDR2[2 +: log2(DEPTH_WORDS)]; higher bits ignored (aliasing wrap-around).
REQ-016 An access SHALL be illegal when: half with addr[0]=1; word with addr[1:0]!=0; size 11 in any case.
REQ-017 RAM store SHALL occur on the edge where MEM_WE2=1, MEM_RESET=1, region RAM, access legal.
REQ-018 Store byte lanes SHALL be: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four; unaffected lanes unchanged.
REQ-019 Store data SHALL be DIN2[7:0] / DIN2[15:0] / DIN2[31:0] shifted to the selected lanes.
REQ-020 IO_WR SHALL be combinational: MEM_WE2 & region IO & MEM_RESET; IO stores SHALL NOT touch RAM; IO stores ignore alignment.
REQ-021 Load SHALL have 1-cycle latency: fields (word/IOBUS_IN, addr[1:0], MEM_SIZE, region, legal) sampled at edge N when MEM_RDEN2=1; MEM_DOUT2 valid after edge N.
REQ-022 MEM_DOUT2 SHALL be formed from the registered fields: byte/half extracted at registered offset; sign-extended if MEM_SIZE[2]=0, zero-extended if 1; word passed unchanged.
REQ-023 IO loads SHALL return IOBUS_IN sampled at edge N, with the same size/extension rules.
REQ-024 Illegal load SHALL produce MEM_DOUT2 = 0.
REQ-025 When MEM_RDEN2=0 at an edge, MEM_DOUT2 SHALL hold its previous value.
REQ-026 Simultaneous MEM_WE2 and MEM_RDEN2 to the same word SHALL be read-before-write: load returns pre-store data; store still completes.
REQ-027 Illegal store SHALL be suppressed entirely (no lane written).
REQ-028 MEM_ERR SHALL set on the edge after any illegal RAM access (load or store) and stay 1 until reset.
REQ-029 Back-to-back loads SHALL be supported every cycle with no bubbles.

Reset
REQ-030 While MEM_RESET=0 at an edge: MEM_DOUT2 <= 0, MEM_ERR <= 0, registered load fields <= 0, RAM writes suppressed, IO_WR = 0.
REQ-031 RAM contents SHALL NOT be cleared by reset; a load in flight when reset asserts SHALL be discarded (MEM_DOUT2 = 0).

Verification
REQ-032 Store word 0xDEADBEEF @0x100, load word @0x100 next cycle -> MEM_DOUT2 = 0xDEADBEEF one edge after RDEN2.
REQ-033 Store byte 0x80 @0x103 over 0x00000000; lb @0x103 -> 0xFFFFFF80; lbu -> 0x00000080; lw @0x100 -> 0x80000000.
REQ-034 Half store 0x1234 @0x202, then lh @0x201 -> MEM_DOUT2 = 0, MEM_ERR = 1 and stays 1; lhu @0x202 -> 0x00001234.
REQ-035 WE2 and RDEN2 same cycle @0x300 (old 0x11111111, new 0x22222222) -> load 0x11111111; following load 0x22222222.
REQ-036 sw @0x1100_0000 -> IO_WR = 1 same cycle, RAM @0x0 unchanged; lw @0x1100_0004 with IOBUS_IN = 0xA5A5A5A5 -> 0xA5A5A5A5.
REQ-037 Load issued, MEM_RESET=0 at the next edge -> MEM_DOUT2 = 0, MEM_ERR = 0; after release, prior RAM data still readable.

Source files
------------

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data-side memory responder for a small RISC-V style core. Byte-addressed
// accesses are decoded into a word-organised RAM (byte-lane writes) or passed
// to an external IO bus when the address is at or above IO_BASE. Loads have a
// fixed one-cycle latency. The load result is sign- or zero-extended to 32 bits.
// Misaligned or illegal-size RAM accesses are suppressed, and they raise a
// sticky error flag.
//
// Parameters
//   DEPTH_WORDS  RAM size in 32-bit words (power of two)
//   IO_BASE      lowest byte address routed to the IO bus
//
// Ports
//   MEM_CLOCK  in   1   sole clock, rising edge
//   MEM_RESET  in   1   synchronous, active-low reset
//   MEM_ADDR2  in   32  byte address of the data access
//   MEM_DIN2   in   32  store data, right-justified
//   MEM_WE2    in   1   store request this cycle
//   MEM_RDEN2  in   1   load request this cycle
//   MEM_SIZE   in   3   [1:0] 00 byte / 01 half / 10 word, [2] 1 = zero-extend
//   IOBUS_IN   in   32  read data from IO devices
//   MEM_DOUT2  out  32  load result, valid the cycle after MEM_RDEN2
//   IO_WR      out  1   IO store strobe (combinational)
//   MEM_ERR    out  1   sticky misaligned / illegal-size flag
// ---------------------------------------------------------------------------
module data_mem_responder #(
   parameter int          DEPTH_WORDS = 16384,
   parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
   input  logic        MEM_CLOCK,
   input  logic        MEM_RESET,
   input  logic [31:0] MEM_ADDR2,
   input  logic [31:0] MEM_DIN2,
   input  logic        MEM_WE2,
   input  logic        MEM_RDEN2,
   input  logic [2:0]  MEM_SIZE,
   input  logic [31:0] IOBUS_IN,
   output logic [31:0] MEM_DOUT2,
   output logic        IO_WR,
   output logic        MEM_ERR
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // RAM is stored as four byte lanes per word so partial stores only touch
   // the selected lanes.
   logic [3:0][7:0] ram [DEPTH_WORDS];

   logic [AW-1:0] wordIdx;
   logic          isIo;
   logic          accessLegal;
   logic          ramWrite;
   logic [3:0]    laneEn;
   logic [31:0]   laneData;
   logic [31:0]   ramRdWord;

   // Registered load fields and their next-state values
   logic [31:0] ldWord_q,   ldWord_d;
   logic [1:0]  ldOffset_q, ldOffset_d;
   logic [2:0]  ldSize_q,   ldSize_d;
   logic        ldLegal_q,  ldLegal_d;
   logic        err_q,      err_d;

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Address bits above the RAM index are ignored, so RAM aliases through the
   // whole region below IO_BASE.
   assign isIo      = (MEM_ADDR2 >= IO_BASE);
   assign wordIdx   = MEM_ADDR2[2 +: AW];
   assign ramRdWord = ram[wordIdx];

   // Legality: halves need an even address, words need a word-aligned
   // address, and size code 11 is never legal.
   always_comb begin
      accessLegal = 1'b0;
      case (MEM_SIZE[1:0])
         SZ_BYTE: accessLegal = 1'b1;
         SZ_HALF: accessLegal = ~MEM_ADDR2[0];
         SZ_WORD: accessLegal = (MEM_ADDR2[1:0] == 2'b00);
         default: accessLegal = 1'b0;
      endcase
   end

   // Store lane selection. The store data is replicated across the word,
   // so only the enable mask has to follow the address offset.
   always_comb begin
      laneEn   = 4'b0000;
      laneData = 32'h0;
      case (MEM_SIZE[1:0])
         SZ_BYTE: begin
            laneEn   = 4'b0001 << MEM_ADDR2[1:0];
            laneData = {4{MEM_DIN2[7:0]}};
         end
         SZ_HALF: begin
            laneEn   = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
            laneData = {2{MEM_DIN2[15:0]}};
         end
         SZ_WORD: begin
            laneEn   = 4'b1111;
            laneData = MEM_DIN2;
         end
         default: begin
            laneEn   = 4'b0000;
            laneData = 32'h0;
         end
      endcase
   end

   // IO stores skip the legality check, and they never reach the RAM.
   assign IO_WR    = MEM_WE2 & isIo & MEM_RESET;
   assign ramWrite = MEM_WE2 & ~isIo & accessLegal & MEM_RESET;

   // RAM write port. Contents are intentionally left untouched by reset.
   always_ff @(posedge MEM_CLOCK) begin
      if (ramWrite) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (laneEn[lane]) begin
               ram[wordIdx][lane] <= laneData[8*lane +: 8];
            end
         end
      end
   end

   // Next-state for the load pipeline and the sticky error. The word is
   // captured before this edge's store lands, which gives read-before-write
   // behaviour when a load and a store hit the same word. Without a load,
   // the fields hold, so MEM_DOUT2 also holds.
   always_comb begin
      ldWord_d   = ldWord_q;
      ldOffset_d = ldOffset_q;
      ldSize_d   = ldSize_q;
      ldLegal_d  = ldLegal_q;
      if (MEM_RDEN2) begin
         ldWord_d   = isIo ? IOBUS_IN : ramRdWord;
         ldOffset_d = MEM_ADDR2[1:0];
         ldSize_d   = MEM_SIZE;
         ldLegal_d  = accessLegal;
      end
      err_d = err_q | (~isIo & ~accessLegal & (MEM_WE2 | MEM_RDEN2));
   end

   // Load fields and error flag. Reset discards a load in flight.
   always_ff @(posedge MEM_CLOCK) begin
      if (!MEM_RESET) begin
         ldWord_q   <= 32'h0;
         ldOffset_q <= 2'b00;
         ldSize_q   <= 3'b000;
         ldLegal_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ldWord_q   <= ldWord_d;
         ldOffset_q <= ldOffset_d;
         ldSize_q   <= ldSize_d;
         ldLegal_q  <= ldLegal_d;
         err_q      <= err_d;
      end
   end

   // Load result formatting from the registered fields. An illegal load
   // returns zero.
   always_comb begin
      byteSel   = ldWord_q[{ldOffset_q, 3'b000} +: 8];
      halfSel   = ldWord_q[{ldOffset_q[1], 4'b0000} +: 16];
      MEM_DOUT2 = 32'h0;
      if (ldLegal_q) begin
         case (ldSize_q[1:0])
            SZ_BYTE: MEM_DOUT2 = {{24{~ldSize_q[2] & byteSel[7]}}, byteSel};
            SZ_HALF: MEM_DOUT2 = {{16{~ldSize_q[2] & halfSel[15]}}, halfSel};
            SZ_WORD: MEM_DOUT2 = ldWord_q;
            default: MEM_DOUT2 = 32'h0;
         endcase
      end
   end

   assign MEM_ERR = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Scoreboard bench for data_mem_responder. Each driven cycle runs through a
// byte-array reference model. The model result (load value, error flag and an
// optional fixed value for directed cases) is pushed onto a queue. A separate
// monitor pops one entry after each rising edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int          DEPTH   = 16384;
   localparam int unsigned RANGE   = DEPTH * 4;
   localparam logic [31:0] IO_BASE = 32'h1100_0000;

   logic        clk;
   logic        rstN;
   logic [31:0] addr;
   logic [31:0] din;
   logic        we;
   logic        rden;
   logic [2:0]  size;
   logic [31:0] iobus;
   logic [31:0] dout;
   logic        ioWr;
   logic        memErr;

   typedef struct {
      logic [31:0] dout;
      logic        err;
      bit          fixEn;
      logic [31:0] fixVal;
      string       name;
   } exp_t;

   exp_t sbQ[$];

   // Reference model state: a flat byte array, plus the last load result and the sticky error
   logic [7:0]  mdl [RANGE];
   logic [31:0] mdlDout;
   logic        mdlErr;

   int total;
   int bad;

   data_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .IO_BASE    (IO_BASE)
   ) dut (
      .MEM_CLOCK(clk),
      .MEM_RESET(rstN),
      .MEM_ADDR2(addr),
      .MEM_DIN2 (din),
      .MEM_WE2  (we),
      .MEM_RDEN2(rden),
      .MEM_SIZE (size),
      .IOBUS_IN (iobus),
      .MEM_DOUT2(dout),
      .IO_WR    (ioWr),
      .MEM_ERR  (memErr)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // One comparison: bumps the counters and reports any difference
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle at the falling edge and checks the combinational IO
   // strobe. It then advances the reference model and queues the expected
   // post-edge state.
   task automatic applyStimulus(input bit rst, input bit w, input bit r,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] sz, input logic [31:0] io,
                                input bit fixEn, input logic [31:0] fixVal,
                                input string name);
      int unsigned nbytes;
      int unsigned off;
      int unsigned base;
      bit          legal;
      bit          isIo;
      logic [31:0] src;
      logic [63:0] v;
      logic [63:0] mask;
      exp_t        e;

      @(negedge clk);
      rstN  = rst;
      we    = w;
      rden  = r;
      addr  = a;
      din   = d;
      size  = sz;
      iobus = io;

      isIo   = (a >= IO_BASE);
      nbytes = 1 << sz[1:0];
      off    = a % 4;
      legal  = (sz[1:0] != 2'b11) && ((off % nbytes) == 0);

      #1;
      checkOutput("io_wr", {31'b0, ioWr}, {31'b0, (rst && w && isIo)});

      if (!rst) begin
         mdlDout = 32'h0;
         mdlErr  = 1'b0;
      end else begin
         if (r) begin
            if (isIo) begin
               src = io;
            end else begin
               base = (a - off) % RANGE;
               src  = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
            end
            if (!legal) begin
               mdlDout = 32'h0;
            end else begin
               mask = (64'd1 << (8 * nbytes)) - 64'd1;
               v    = ({32'h0, src} >> (8 * off)) & mask;
               if (!sz[2] && nbytes < 4 && v[8*nbytes-1]) begin
                  v = v | (~mask & 64'h0000_0000_FFFF_FFFF);
               end
               mdlDout = v[31:0];
            end
         end
         if (!isIo && !legal && (w || r)) begin
            mdlErr = 1'b1;
         end
         if (w && !isIo && legal) begin
            for (int k = 0; k < int'(nbytes); k++) begin
               mdl[((a % RANGE) + k) % RANGE] = 8'(d >> (8 * k));
            end
         end
      end

      e.dout   = mdlDout;
      e.err    = mdlErr;
      e.fixEn  = fixEn;
      e.fixVal = fixVal;
      e.name   = name;
      sbQ.push_back(e);
   endtask

   // Monitor: one queued expectation per rising edge, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("dout", dout, e.dout);
            checkOutput("mem_err", {31'b0, memErr}, {31'b0, e.err});
            if (e.fixEn) begin
               checkOutput(e.name, dout, e.fixVal);
            end
         end
      end
   end

   // Stimulus: reset, RAM initialisation, directed cases, then random traffic
   initial begin
      logic [31:0] ra;
      logic [2:0]  rs;
      bit          rw;
      bit          rr;
      bit          rrst;

      total = 0;
      bad   = 0;
      rstN  = 1'b0;
      we    = 1'b0;
      rden  = 1'b0;
      addr  = 32'h0;
      din   = 32'h0;
      size  = 3'b000;
      iobus = 32'h0;
      mdlDout = 32'h0;
      mdlErr  = 1'b0;
      for (int i = 0; i < int'(RANGE); i++) mdl[i] = 8'h00;

      // Reset state
      applyStimulus(0, 0, 1, 32'h0, 32'h0, 3'b010, 32'h0, 1, 32'h0, "reset_dout");
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0, 1, 32'h0, "reset_hold");

      // Fill the working region so every later load reads defined data
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1, 1, 0, 32'(i * 4), $urandom, 3'b010, 32'h0, 0, 32'h0, "init");
      end

      // Word store then load
      applyStimulus(1, 1, 0, 32'h100, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0, 1, 32'hDEAD_BEEF, "lw_100");
      applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b010, 32'h0, 1, 32'hDEAD_BEEF, "hold");

      // Byte store with sign and zero extension
      applyStimulus(1, 1, 0, 32'h100, 32'h0, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 1, 0, 32'h103, 32'h1234_5680, 3'b000, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 0, 1, 32'h103, 32'h0, 3'b000, 32'h0, 1, 32'hFFFF_FF80, "lb_103");
      applyStimulus(1, 0, 1, 32'h103, 32'h0, 3'b100, 32'h0, 1, 32'h0000_0080, "lbu_103");
      applyStimulus(1, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0, 1, 32'h8000_0000, "lw_100b");
      applyStimulus(1, 0, 1, 32'h0001_0100, 32'h0, 3'b010, 32'h0, 1, 32'h8000_0000, "alias_lw");

      // Half store, then a misaligned half load that sets the sticky error
      applyStimulus(1, 1, 0, 32'h200, 32'h0, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 1, 0, 32'h202, 32'hABCD_1234, 3'b001, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 0, 1, 32'h201, 32'h0, 3'b001, 32'h0, 1, 32'h0, "lh_misaligned");
      applyStimulus(1, 0, 1, 32'h202, 32'h0, 3'b101, 32'h0, 1, 32'h0000_1234, "lhu_202");
      applyStimulus(1, 0, 1, 32'h200, 32'h0, 3'b010, 32'h0, 1, 32'h1234_0000, "lw_200");

      // Store and load of the same word in one cycle
      applyStimulus(1, 1, 0, 32'h300, 32'h1111_1111, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 1, 1, 32'h300, 32'h2222_2222, 3'b010, 32'h0, 1, 32'h1111_1111, "rbw_old");
      applyStimulus(1, 0, 1, 32'h300, 32'h0, 3'b010, 32'h0, 1, 32'h2222_2222, "rbw_new");

      // IO store leaves RAM word 0 alone; IO load returns the bus value
      applyStimulus(1, 1, 0, 32'h0, 32'h5A5A_0001, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 1, 0, IO_BASE, 32'hCAFE_F00D, 3'b010, 32'h0, 0, 32'h0, "");
      applyStimulus(1, 0, 1, 32'h0, 32'h0, 3'b010, 32'h0, 1, 32'h5A5A_0001, "ram0_intact");
      applyStimulus(1, 0, 1, IO_BASE + 32'h4, 32'h0, 3'b010, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, "io_lw");
      applyStimulus(1, 0, 1, IO_BASE + 32'h4, 32'h0, 3'b000, 32'hA5A5_A5A5, 1, 32'hFFFF_FFA5, "io_lb");

      // A reset on the edge after a load discards that load; RAM data survives the reset
      applyStimulus(1, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0, 1, 32'h8000_0000, "pre_reset");
      applyStimulus(0, 1, 1, 32'h100, 32'hFFFF_FFFF, 3'b010, 32'h0, 1, 32'h0, "reset_discard");
      applyStimulus(1, 0, 1, 32'h100, 32'h0, 3'b010, 32'h0, 1, 32'h8000_0000, "after_reset");

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         rrst = ($urandom_range(0, 49) != 0);
         rw   = $urandom_range(0, 1);
         rr   = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) begin
            ra = IO_BASE + (32'($urandom_range(0, 63)) << 2);
            rs = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         end else begin
            ra = 32'($urandom_range(0, 32'h3FF)) + (32'($urandom_range(0, 15)) << 16);
            rs[2]   = 1'($urandom_range(0, 1));
            rs[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         end
         applyStimulus(rrst, rw, rr, ra, $urandom, rs, $urandom, 0, 32'h0, "");
      end

      applyStimulus(1, 0, 0, 32'h0, 32'h0, 3'b000, 32'h0, 0, 32'h0, "");
      repeat (3) @(negedge clk);
      checkOutput("drain", 32'(sbQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
